// File: rtl/spram_arb.sv
// spram_arb: shares one single-port-style RAM (separate write/read ports,
// registered read address, one-cycle read latency) between two requesters.
// Port A is the CPU side, port B the video/DMA side. At most one access is
// granted per clock; read data returns with a per-port valid one cycle later.
module spram_arb #(
  parameter int width   = 8,
  parameter int widthad = 10,
  parameter int rr      = 1,
  parameter int maxwait = 15
) (
  input  logic               clk,
  input  logic               reset,
  // port A (CPU)
  input  logic               a_req,
  input  logic               a_we,
  input  logic [widthad-1:0] a_addr,
  input  logic [width-1:0]   a_wdata,
  output logic               a_ack,
  output logic               a_rvalid,
  output logic [width-1:0]   a_rdata,
  // port B (video / DMA)
  input  logic               b_req,
  input  logic               b_we,
  input  logic [widthad-1:0] b_addr,
  input  logic [width-1:0]   b_wdata,
  output logic               b_ack,
  output logic               b_rvalid,
  output logic [width-1:0]   b_rdata,
  // RAM side
  output logic [widthad-1:0] ram_wraddress,
  output logic               ram_wren,
  output logic [width-1:0]   ram_data,
  output logic [widthad-1:0] ram_rdaddress,
  input  logic [width-1:0]   ram_q
);

  // A zero maxwait still needs a one-bit counter so the declarations stay legal.
  localparam int BW = (maxwait > 0) ? $clog2(maxwait + 1) : 1;
  localparam logic [BW-1:0] MAXW = BW'(maxwait);

  // last_q: 1'b1 means B was granted last, 1'b0 means A.
  logic          last_q, last_d;
  logic [BW-1:0] bwait_q, bwait_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  logic          grant_a, grant_b, force_b;

  // Combinational arbitration: pick at most one winner this cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    force_b = 1'b0;
    if (reset) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end else if (rr != 0) begin
      if (a_req && b_req) begin
        // Contention goes to the port that was not served last.
        grant_a = last_q;
        grant_b = ~last_q;
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end else begin
      // Starvation guard: B wins once it has waited maxwait cycles.
      force_b = (maxwait != 0) && (bwait_q == MAXW) && b_req;
      if (a_req && !force_b) begin
        grant_a = 1'b1;
      end else begin
        grant_b = b_req;
      end
    end
  end

  // Next-state logic for last winner, B wait counter and read-valid strobes.
  always_comb begin
    last_d     = last_q;
    bwait_d    = bwait_q;
    a_rvalid_d = grant_a & ~a_we;
    b_rvalid_d = grant_b & ~b_we;
    if (grant_a) begin
      last_d = 1'b0;
    end else if (grant_b) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    if (b_req && !grant_b) begin
      if (bwait_q == MAXW) begin
        bwait_d = bwait_q;
      end else begin
        bwait_d = bwait_q + BW'(1);
      end
    end else begin
      bwait_d = '0;
    end
  end

  // State register; reset makes A win the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= 1'b1;
      bwait_q    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      bwait_q    <= bwait_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // RAM port mux: winner drives address/data; A's values when idle.
  always_comb begin
    ram_wraddress = a_addr;
    ram_data      = a_wdata;
    ram_wren      = 1'b0;
    if (grant_b) begin
      ram_wraddress = b_addr;
      ram_data      = b_wdata;
      ram_wren      = b_we;
    end else if (grant_a) begin
      ram_wren      = a_we;
    end else begin
      ram_wren      = 1'b0;
    end
  end

  // The RAM registers the read address itself, so both ports share one address.
  assign ram_rdaddress = ram_wraddress;

  assign a_ack    = grant_a;
  assign b_ack    = grant_b;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

endmodule

// File: tb/tb_spram_arb.sv
// Testbench for spram_arb: three instances (round-robin, fixed priority with
// maxwait=3, fixed priority without guard) share one stimulus stream, each
// with its own behavioural RAM, and are compared against a per-config model.
module tb_spram_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [9:0] a_addr = 10'd0, b_addr = 10'd0;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;

  logic a_ack_w [3];
  logic b_ack_w [3];
  logic a_rvalid_w [3];
  logic b_rvalid_w [3];
  logic ram_wren_w [3];
  logic [7:0] a_rdata_w [3];
  logic [7:0] b_rdata_w [3];
  logic [7:0] ram_data_w [3];
  logic [7:0] ram_q_w [3];
  logic [9:0] ram_wraddress_w [3];
  logic [9:0] ram_rdaddress_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [7:0] mem [0:1023];
    logic [9:0] rdaddr_q;

    spram_arb #(
      .width(8), .widthad(10),
      .rr((g == 0) ? 1 : 0),
      .maxwait((g == 0) ? 15 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack_w[g]), .a_rvalid(a_rvalid_w[g]), .a_rdata(a_rdata_w[g]),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack_w[g]), .b_rvalid(b_rvalid_w[g]), .b_rdata(b_rdata_w[g]),
      .ram_wraddress(ram_wraddress_w[g]), .ram_wren(ram_wren_w[g]),
      .ram_data(ram_data_w[g]), .ram_rdaddress(ram_rdaddress_w[g]),
      .ram_q(ram_q_w[g])
    );

    // Behavioural RAM: write at the edge, registered read address.
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (ram_wren_w[g]) begin
        mem[ram_wraddress_w[g]] <= ram_data_w[g];
      end
      rdaddr_q <= ram_rdaddress_w[g];
    end
    assign ram_q_w[g] = mem[rdaddr_q];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per configuration (addresses kept within 0..15).
  int   m_last [3];   // 0 = A, 1 = B
  int   m_wait [3];
  logic m_rva [3];
  logic m_rvb [3];
  int   m_rd [3];
  int   exp_mem [3][16];
  logic seen_a [3];
  logic seen_b [3];
  logic seen_wren [3];

  function automatic int cfg_rr(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int cfg_mw(input int k);
    return (k == 0) ? 15 : ((k == 1) ? 3 : 0);
  endfunction

  // -1 none, 0 port A, 1 port B
  function automatic int winner(input int k);
    if (reset) return -1;
    if (a_req && b_req) begin
      if (cfg_rr(k) != 0) return (m_last[k] == 1) ? 0 : 1;
      return (cfg_mw(k) != 0 && m_wait[k] >= cfg_mw(k)) ? 1 : 0;
    end
    if (a_req) return 0;
    if (b_req) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_last[k] = 1;
      m_wait[k] = 0;
      m_rva[k]  = 1'b0;
      m_rvb[k]  = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s[cfg%0d]: observed %0h expected %0h", tag, k, obs, exp_v);
    end
  endtask

  // One clock: check outputs against the model, take the edge, advance model.
  task automatic step();
    int w [3];
    #1;
    if (reset) model_reset();
    for (int k = 0; k < 3; k++) begin
      w[k] = winner(k);
      seen_a[k]    = a_ack_w[k];
      seen_b[k]    = b_ack_w[k];
      seen_wren[k] = ram_wren_w[k];
      chk("a_ack", k, a_ack_w[k], (w[k] == 0));
      chk("b_ack", k, b_ack_w[k], (w[k] == 1));
      chk("ram_wren", k, ram_wren_w[k], (w[k] == 0 && a_we) || (w[k] == 1 && b_we));
      if (w[k] >= 0) begin
        chk("ram_wraddress", k, ram_wraddress_w[k], (w[k] == 0) ? a_addr : b_addr);
        chk("ram_rdaddress", k, ram_rdaddress_w[k], (w[k] == 0) ? a_addr : b_addr);
        if ((w[k] == 0) ? a_we : b_we)
          chk("ram_data", k, ram_data_w[k], (w[k] == 0) ? a_wdata : b_wdata);
      end
      chk("a_rvalid", k, a_rvalid_w[k], m_rva[k]);
      chk("b_rvalid", k, b_rvalid_w[k], m_rvb[k]);
      if (m_rva[k]) chk("a_rdata", k, a_rdata_w[k], m_rd[k]);
      if (m_rvb[k]) chk("b_rdata", k, b_rdata_w[k], m_rd[k]);
    end
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_rva[k] = 1'b0;
        m_rvb[k] = 1'b0;
        if (w[k] == 0) begin
          m_last[k] = 0;
          if (a_we) exp_mem[k][a_addr[3:0]] = int'(a_wdata);
          else begin m_rva[k] = 1'b1; m_rd[k] = exp_mem[k][a_addr[3:0]]; end
        end else if (w[k] == 1) begin
          m_last[k] = 1;
          if (b_we) exp_mem[k][b_addr[3:0]] = int'(b_wdata);
          else begin m_rvb[k] = 1'b1; m_rd[k] = exp_mem[k][b_addr[3:0]]; end
        end
        if (b_req && w[k] != 1) m_wait[k] = (m_wait[k] + 1 > cfg_mw(k)) ? cfg_mw(k) : m_wait[k] + 1;
        else m_wait[k] = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic rand_inputs(input int pa, input int pb);
    a_req   = ($urandom_range(99) < pa);
    b_req   = ($urandom_range(99) < pb);
    a_we    = $urandom_range(1);
    b_we    = $urandom_range(1);
    a_addr  = 10'($urandom_range(15));
    b_addr  = 10'($urandom_range(15));
    a_wdata = 8'($urandom_range(255));
    b_wdata = 8'($urandom_range(255));
  endtask

  initial begin
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++) exp_mem[k][j] = 0;
    model_reset();
    repeat (2) step();
    mem_clr = 1'b0;
    reset   = 1'b0;

    // A write 0x5A to 3, then read it back.
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd3; a_wdata = 8'h5A;
    step();
    chk("t1_wr_ack", 0, seen_a[0], 1'b1);
    a_we = 1'b0;
    step();
    chk("t1_rd_ack", 0, seen_a[0], 1'b1);
    chk("t1_rvalid", 0, a_rvalid_w[0], 1'b1);
    chk("t1_rdata", 0, a_rdata_w[0], 8'h5A);
    chk("t1_b_rvalid", 0, b_rvalid_w[0], 1'b0);
    a_req = 1'b0;
    step();

    // Round-robin alternation with both ports reading continuously.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd2;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_a_alt", 0, seen_a[0], (i % 2 == 0));
      chk("t2_b_alt", 0, seen_b[0], (i % 2 == 1));
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    // Fixed priority, maxwait=3: B forced in on its 4th waiting cycle.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd4;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_b_forced", 1, seen_b[1], (i == 3));
    end
    b_req = 1'b0;
    step();
    chk("t3_a_after", 1, seen_a[1], 1'b1);
    a_req = 1'b0;
    step();

    // Fixed priority, guard disabled: B never wins under contention.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_inputs(100, 100);
      step();
      chk("t4_no_b", 2, seen_b[2], 1'b0);
      chk("t4_wren", 2, seen_wren[2], a_we);
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    // A writes 0x11 to 7, B reads 7 the next cycle.
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'd7; a_wdata = 8'h11;
    step();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'd7;
    step();
    b_req = 1'b0;
    chk("t5_b_rvalid", 0, b_rvalid_w[0], 1'b1);
    chk("t5_b_rdata", 0, b_rdata_w[0], 8'h11);
    step();

    // Reset pulse right after a read ack suppresses the pending rvalid.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'd3;
    step();
    reset = 1'b1;
    a_req = 1'b0;
    #1;
    chk("t6_rv_killed", 0, a_rvalid_w[0], 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("t6_idle_a", 0, seen_a[0], 1'b0);
    chk("t6_idle_wren", 0, seen_wren[0], 1'b0);
    a_req = 1'b1; b_req = 1'b1;
    step();
    for (int k = 0; k < 3; k++) chk("t6_first_a", k, seen_a[k], 1'b1);
    a_req = 1'b0; b_req = 1'b0;
    step();

    // Random traffic, light then heavy contention, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rand_inputs(50, 50);
      reset = ($urandom_range(99) < 3);
      step();
    end
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rand_inputs(95, 85);
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
